// File: rtl/noc_pkg.sv
// Shared mesh-router definitions.
//   NUM_PORTS  : router radix (N, S, E, W, Local)
//   PORT_IDX_W : width of a port index
//   port_e     : port encoding, identical for inputs and outputs
//   route_xy() : dimension-ordered route computation (XY or YX)
package noc_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int PORT_IDX_W = 3;

  typedef enum logic [PORT_IDX_W-1:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  // mode=0: resolve X first, then Y. mode=1: resolve Y first, then X.
  // All coordinate compares are unsigned.
  function automatic port_e route_xy(input int unsigned dx,
                                     input int unsigned dy,
                                     input int unsigned my_x,
                                     input int unsigned my_y,
                                     input logic        mode);
    port_e r;
    r = PORT_L;
    if (!mode) begin
      if      (dx > my_x) r = PORT_E;
      else if (dx < my_x) r = PORT_W;
      else if (dy > my_y) r = PORT_N;
      else if (dy < my_y) r = PORT_S;
    end else begin
      if      (dy > my_y) r = PORT_N;
      else if (dy < my_y) r = PORT_S;
      else if (dx > my_x) r = PORT_E;
      else if (dx < my_x) r = PORT_W;
    end
    return r;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Handshake bundle between input buffers, switch allocator and crossbar.
//   in_valid/in_head/in_tail/packet_addr : per-input flit presentation
//   buffer_full_in                       : per-output downstream back-pressure
//   grant/grant_v                        : per-output crossbar select + transfer
//   in_ack                               : per-input pop
//   out_locked                           : per-output wormhole lock status
// master = flit source / testbench side, slave = allocator.
interface switch_allocator_if #(
  parameter int ADDR_W = 8
);
  localparam int NP = noc_pkg::NUM_PORTS;

  logic [NP-1:0]             in_valid;
  logic [NP-1:0]             in_head;
  logic [NP-1:0]             in_tail;
  logic [NP-1:0][ADDR_W-1:0] packet_addr;
  logic [NP-1:0]             buffer_full_in;
  logic [NP-1:0][NP-1:0]     grant;
  logic [NP-1:0]             grant_v;
  logic [NP-1:0]             in_ack;
  logic [NP-1:0]             out_locked;

  modport master (
    output in_valid, in_head, in_tail, packet_addr, buffer_full_in,
    input  grant, grant_v, in_ack, out_locked
  );

  modport slave (
    input  in_valid, in_head, in_tail, packet_addr, buffer_full_in,
    output grant, grant_v, in_ack, out_locked
  );

endinterface

// File: rtl/rr_lock_arbiter.sv
// Per-output arbiter: round-robin among head requests while unlocked, owner-only
// body/tail service while locked, stalled by downstream full.
//   clk, rst     : clock, asynchronous active-low reset
//   req_head_i   : inputs presenting a head flit routed to this output
//   req_body_i   : inputs presenting a body/tail flit whose latched route is this output
//   tail_i       : per-input tail flag of the presented flit
//   full_i       : downstream buffer of this output is full
//   grant_o      : one-hot winner, zero unless grant_v_o
//   grant_v_o    : a flit transfers on this output this cycle
//   locked_o     : output held by an in-progress packet
module rr_lock_arbiter
  import noc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PORTS-1:0]  req_head_i,
  input  logic [NUM_PORTS-1:0]  req_body_i,
  input  logic [NUM_PORTS-1:0]  tail_i,
  input  logic                  full_i,
  output logic [NUM_PORTS-1:0]  grant_o,
  output logic                  grant_v_o,
  output logic                  locked_o
);

  logic                  lock_q, lock_d;
  logic [PORT_IDX_W-1:0] owner_q, owner_d;
  logic [PORT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_IDX_W-1:0] winner;
  logic [PORT_IDX_W:0]   idx;
  logic                  found;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found     = 1'b0;
    winner    = '0;
    idx       = '0;
    grant_o   = '0;
    lock_d    = lock_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;

    if (lock_q) begin
      // Locked: only the owner's non-head flit may advance; other heads wait.
      found  = req_body_i[owner_q];
      winner = owner_q;
    end else begin
      // Unlocked: first head request at or above rr_ptr, wrapping at NUM_PORTS.
      for (int off = 0; off < NUM_PORTS; off++) begin
        idx = {1'b0, rr_ptr_q} + (PORT_IDX_W+1)'(off);
        if (idx >= (PORT_IDX_W+1)'(NUM_PORTS)) idx = idx - (PORT_IDX_W+1)'(NUM_PORTS);
        if (!found && req_head_i[idx[PORT_IDX_W-1:0]]) begin
          found  = 1'b1;
          winner = idx[PORT_IDX_W-1:0];
        end
      end
    end

    // Reset gates the combinational grant path so outputs stay quiet in reset.
    grant_v_o = found && !full_i && rst;
    if (grant_v_o) grant_o[winner] = 1'b1;

    if (grant_v_o) begin
      if (!lock_q) begin
        rr_ptr_d = (winner == PORT_IDX_W'(NUM_PORTS-1)) ? '0 : winner + 1'b1;
        if (!tail_i[winner]) begin
          lock_d  = 1'b1;
          owner_d = winner;
        end
      end else if (tail_i[winner]) begin
        lock_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q   <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign locked_o = lock_q;

endmodule

// File: rtl/switch_allocator.sv
// 5-port mesh-router switch allocator.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : switch_allocator_if.slave -- flit requests in; grant, grant_v,
//              in_ack and out_locked out. grant[o] drives crossbar mux select o.
// Computes head routes, remembers each input's route for the rest of its packet,
// fans requests out to one rr_lock_arbiter per output and ORs grants into in_ack.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int          X_W        = 4,
  parameter int          Y_W        = 4,
  parameter int unsigned MY_X       = 0,
  parameter int unsigned MY_Y       = 0,
  parameter int          ROUTE_MODE = 0
)(
  input  logic               clk,
  input  logic               rst,
  switch_allocator_if.slave  bus
);

  localparam int ADDR_W = X_W + Y_W;

  port_e head_route [NUM_PORTS];
  port_e route_q    [NUM_PORTS];
  port_e route_d    [NUM_PORTS];

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant_w;
  logic [NUM_PORTS-1:0]                grant_v_w;
  logic [NUM_PORTS-1:0]                locked_w;
  logic [NUM_PORTS-1:0]                ack;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      head_route[i] = route_xy(32'(bus.packet_addr[i][ADDR_W-1:Y_W]),
                               32'(bus.packet_addr[i][Y_W-1:0]),
                               MY_X, MY_Y, ROUTE_MODE != 0);
    end
  end

  // Each input can target only one output, so at most one grant bit per column.
  always_comb begin
    ack = '0;
    for (int o = 0; o < NUM_PORTS; o++) ack |= grant_w[o];
  end

  // A transferred multi-flit head pins its input's route until the packet ends.
  always_comb begin
    route_d = route_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ack[i] && bus.in_head[i] && !bus.in_tail[i]) route_d[i] = head_route[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: route_q is reset too, so a packet cut off by reset cannot leave a stale route behind.
      for (int i = 0; i < NUM_PORTS; i++) route_q[i] <= PORT_L;
    end else begin
      route_q <= route_d;
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0] req_head;
    logic [NUM_PORTS-1:0] req_body;

    always_comb begin
      req_head = '0;
      req_body = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req_head[i] = bus.in_valid[i] &&  bus.in_head[i] && (head_route[i] == port_e'(o));
        req_body[i] = bus.in_valid[i] && !bus.in_head[i] && (route_q[i]    == port_e'(o));
      end
    end

    rr_lock_arbiter u_arb (
      .clk        (clk),
      .rst        (rst),
      .req_head_i (req_head),
      .req_body_i (req_body),
      .tail_i     (bus.in_tail),
      .full_i     (bus.buffer_full_in[o]),
      .grant_o    (grant_w[o]),
      .grant_v_o  (grant_v_w[o]),
      .locked_o   (locked_w[o])
    );
  end

  assign bus.grant      = grant_w;
  assign bus.grant_v    = grant_v_w;
  assign bus.out_locked = locked_w;
  assign bus.in_ack     = ack;

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator (MY_X=1, MY_Y=1, 4-bit coordinates).
// Two DUTs share stimulus: u_dut_xy (XY routing) and u_dut_yx (YX routing).
// Expected outputs are queued when a cycle's stimulus is applied and compared
// on the following falling edge.
module tb_switch_allocator;
  import noc_pkg::*;

  logic clk;
  logic rst;

  switch_allocator_if #(.ADDR_W(8)) bus0 ();
  switch_allocator_if #(.ADDR_W(8)) bus1 ();

  assign bus1.in_valid       = bus0.in_valid;
  assign bus1.in_head        = bus0.in_head;
  assign bus1.in_tail        = bus0.in_tail;
  assign bus1.packet_addr    = bus0.packet_addr;
  assign bus1.buffer_full_in = bus0.buffer_full_in;

  switch_allocator #(.X_W(4), .Y_W(4), .MY_X(1), .MY_Y(1), .ROUTE_MODE(0)) u_dut_xy (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  switch_allocator #(.X_W(4), .Y_W(4), .MY_X(1), .MY_Y(1), .ROUTE_MODE(1)) u_dut_yx (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [24:0] grant;
    logic [4:0]  grant_v;
    logic [4:0]  ack;
    logic [4:0]  locked;
    logic        yx_on;
    logic [24:0] grant_yx;
    logic [4:0]  grant_v_yx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Bit o*5+i of the flattened grant matrix = output o selects input i.
  function automatic logic [24:0] gb(input int o, input int i);
    logic [24:0] v;
    v = '0;
    v[o*5+i] = 1'b1;
    return v;
  endfunction

  task automatic idle();
    bus0.in_valid       = '0;
    bus0.in_head        = '0;
    bus0.in_tail        = '0;
    bus0.packet_addr    = '0;
    bus0.buffer_full_in = '0;
  endtask

  task automatic set_in(input int i, input logic v, input logic h, input logic t,
                        input logic [7:0] a);
    bus0.in_valid[i]    = v;
    bus0.in_head[i]     = h;
    bus0.in_tail[i]     = t;
    bus0.packet_addr[i] = a;
  endtask

  task automatic rand_inputs();
    bus0.in_valid       = 5'($urandom);
    bus0.in_head        = 5'($urandom);
    bus0.in_tail        = 5'($urandom);
    bus0.packet_addr    = {8'($urandom), 32'($urandom)};
    bus0.buffer_full_in = 5'($urandom);
  endtask

  // Queue this cycle's expectation, then advance to just after the next rising edge.
  task automatic expect_out(input string tag, input logic [24:0] g, input logic [4:0] gv,
                            input logic [4:0] ack, input logic [4:0] lck,
                            input logic yx_on, input logic [24:0] g_yx,
                            input logic [4:0] gv_yx);
    exp_t e;
    e.tag = tag; e.grant = g; e.grant_v = gv; e.ack = ack; e.locked = lck;
    e.yx_on = yx_on; e.grant_yx = g_yx; e.grant_v_yx = gv_yx;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".grant"},   32'(bus0.grant),      32'(mon_e.grant));
      check({mon_e.tag, ".grant_v"}, 32'(bus0.grant_v),    32'(mon_e.grant_v));
      check({mon_e.tag, ".in_ack"},  32'(bus0.in_ack),     32'(mon_e.ack));
      check({mon_e.tag, ".locked"},  32'(bus0.out_locked), 32'(mon_e.locked));
      if (mon_e.yx_on) begin
        check({mon_e.tag, ".yx_grant"},   32'(bus1.grant),   32'(mon_e.grant_yx));
        check({mon_e.tag, ".yx_grant_v"}, 32'(bus1.grant_v), 32'(mon_e.grant_v_yx));
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk); #1;

    // Reset holds every output low regardless of inputs.
    for (int c = 0; c < 3; c++) begin
      rand_inputs();
      expect_out("rst_rand", '0, '0, '0, '0, 1'b1, '0, '0);
    end
    idle();
    rst = 1'b1;
    expect_out("idle", '0, '0, '0, '0, 1'b1, '0, '0);

    // Local single-flit packet to (3,1) goes East in the same cycle, no lock.
    set_in(4, 1'b1, 1'b1, 1'b1, 8'h31);
    expect_out("l_single", gb(2, 4), 5'b00100, 5'b10000, 5'b00000, 1'b0, '0, '0);
    idle();
    expect_out("l_single_after", '0, '0, '0, 5'b00000, 1'b0, '0, '0);

    // N and S single-flit packets to self contend for Local: N,S,N,S.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(0, 1'b1, 1'b1, 1'b1, 8'h11);
      set_in(1, 1'b1, 1'b1, 1'b1, 8'h11);
      expect_out("rr_local", gb(4, c % 2), 5'b10000, 5'(1 << (c % 2)), 5'b00000,
                 1'b0, '0, '0);
    end

    // Wormhole: W sends 3 flits East; N's head waits until W's tail has gone.
    do_reset();
    set_in(3, 1'b1, 1'b1, 1'b0, 8'h31);
    expect_out("worm_head", gb(2, 3), 5'b00100, 5'b01000, 5'b00000, 1'b0, '0, '0);
    set_in(3, 1'b1, 1'b0, 1'b0, 8'h31);
    set_in(0, 1'b1, 1'b1, 1'b0, 8'h31);
    expect_out("worm_body", gb(2, 3), 5'b00100, 5'b01000, 5'b00100, 1'b0, '0, '0);
    set_in(3, 1'b1, 1'b0, 1'b1, 8'h31);
    expect_out("worm_tail", gb(2, 3), 5'b00100, 5'b01000, 5'b00100, 1'b0, '0, '0);
    set_in(3, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_out("worm_n_win", gb(2, 0), 5'b00100, 5'b00001, 5'b00000, 1'b0, '0, '0);
    idle();
    expect_out("worm_n_lock", '0, '0, '0, 5'b00100, 1'b0, '0, '0);

    // Same wormhole with East full for two cycles: stall, lock held, resume.
    do_reset();
    set_in(3, 1'b1, 1'b1, 1'b0, 8'h31);
    expect_out("full_head", gb(2, 3), 5'b00100, 5'b01000, 5'b00000, 1'b0, '0, '0);
    set_in(3, 1'b1, 1'b0, 1'b0, 8'h31);
    set_in(0, 1'b1, 1'b1, 1'b0, 8'h31);
    bus0.buffer_full_in = 5'b00100;
    expect_out("full_stall1", '0, '0, '0, 5'b00100, 1'b0, '0, '0);
    expect_out("full_stall2", '0, '0, '0, 5'b00100, 1'b0, '0, '0);
    bus0.buffer_full_in = 5'b00000;
    expect_out("full_resume", gb(2, 3), 5'b00100, 5'b01000, 5'b00100, 1'b0, '0, '0);
    set_in(3, 1'b1, 1'b0, 1'b1, 8'h31);
    expect_out("full_tail", gb(2, 3), 5'b00100, 5'b01000, 5'b00100, 1'b0, '0, '0);
    set_in(3, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_out("full_n_win", gb(2, 0), 5'b00100, 5'b00001, 5'b00000, 1'b0, '0, '0);

    // Routing order: (3,3) from (1,1) is East under XY, North under YX.
    do_reset();
    set_in(4, 1'b1, 1'b1, 1'b1, 8'h33);
    expect_out("route_mode", gb(2, 4), 5'b00100, 5'b10000, 5'b00000,
               1'b1, gb(0, 4), 5'b00001);

    // Reset in the middle of a packet clears the lock and the latched route.
    do_reset();
    set_in(3, 1'b1, 1'b1, 1'b0, 8'h31);
    expect_out("mid_head", gb(2, 3), 5'b00100, 5'b01000, 5'b00000, 1'b0, '0, '0);
    set_in(3, 1'b1, 1'b0, 1'b0, 8'h31);
    expect_out("mid_body", gb(2, 3), 5'b00100, 5'b01000, 5'b00100, 1'b0, '0, '0);
    rst = 1'b0;
    expect_out("mid_in_rst", '0, '0, '0, '0, 1'b1, '0, '0);
    rst = 1'b1;
    expect_out("mid_orphan_body", '0, '0, '0, '0, 1'b1, '0, '0);

    idle();
    @(posedge clk); #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
